// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT twiddle sequencer.
// Holds the FSM state enum, the butterfly descriptor and the (s,b) index helper.
package fft8_pkg;

    localparam int unsigned FFT_N            = 8;
    localparam int unsigned FFT_LOG2N        = 3;
    localparam int unsigned FFT_BF_PER_STAGE = 4;
    localparam int unsigned TW_ADDR_W        = 2;
    localparam int unsigned STAGE_W          = 2;
    localparam int unsigned BF_W             = 2;
    localparam int unsigned IDX_W            = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [STAGE_W-1:0]   stage;
        logic [IDX_W-1:0]     idx_a;
        logic [IDX_W-1:0]     idx_b;
        logic [TW_ADDR_W-1:0] tw_addr;
        logic                 last;
    } bf_desc_t;

    // Operand indices and twiddle address for butterfly b of stage s.
    function automatic bf_desc_t bf_desc(input logic [STAGE_W-1:0] s,
                                         input logic [BF_W-1:0]    b);
        bf_desc_t         d;
        logic [IDX_W-1:0] span;
        d = '0;
        d.stage = s;
        case (s)
            2'd1: begin
                span      = 3'd2;
                d.idx_a   = {b[1], 1'b0, b[0]};
                d.tw_addr = {b[0], 1'b0};
            end
            2'd2: begin
                span      = 3'd4;
                d.idx_a   = {1'b0, b};
                d.tw_addr = b;
            end
            default: begin
                span      = 3'd1;
                d.idx_a   = {b, 1'b0};
                d.tw_addr = 2'd0;
            end
        endcase
        d.idx_b = d.idx_a + span;
        d.last  = (s == 2'd2) && (b == 2'd3);
        return d;
    endfunction

endpackage

// File: rtl/twiddle_rom_8pt.sv
// Registered twiddle ROM for an 8-point FFT: W8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8), k=0..3.
// IEEE-754 single-precision words; one-cycle read latency.
module twiddle_rom_8pt
    import fft8_pkg::*;
#(
    parameter int unsigned W_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TW_ADDR_W-1:0] i_addr,
    output logic [W_WIDTH-1:0]   o_real,
    output logic [W_WIDTH-1:0]   o_imag
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_real <= W_WIDTH'(32'h3F80_0000);
            o_imag <= W_WIDTH'(32'h0000_0000);
        end else begin
            case (i_addr)
                2'd0: begin
                    o_real <= W_WIDTH'(32'h3F80_0000);
                    o_imag <= W_WIDTH'(32'h0000_0000);
                end
                2'd1: begin
                    o_real <= W_WIDTH'(32'h3F35_04F3);
                    o_imag <= W_WIDTH'(32'hBF35_04F3);
                end
                2'd2: begin
                    o_real <= W_WIDTH'(32'h0000_0000);
                    o_imag <= W_WIDTH'(32'hBF80_0000);
                end
                default: begin
                    o_real <= W_WIDTH'(32'hBF35_04F3);
                    o_imag <= W_WIDTH'(32'hBF35_04F3);
                end
            endcase
        end
    end

endmodule

// File: rtl/fft8_twiddle_sequencer.sv
// Schedules the 12 radix-2 DIT butterflies of an 8-point FFT and reads the twiddle ROM.
// Optional macro TWIDDLE_CONJ_EN adds the 'inverse' port for conjugated twiddles.
module fft8_twiddle_sequencer
    import fft8_pkg::*;
#(
    parameter int unsigned W_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef TWIDDLE_CONJ_EN
    input  logic               inverse,
`endif
    output logic               busy,
    output logic               done,
    output logic               bf_valid,
    input  logic               bf_ready,
    output logic [STAGE_W-1:0] bf_stage,
    output logic [IDX_W-1:0]   bf_idx_a,
    output logic [IDX_W-1:0]   bf_idx_b,
    output logic [W_WIDTH-1:0] bf_w_real,
    output logic [W_WIDTH-1:0] bf_w_imag,
    output logic               bf_last
);

    seq_state_t           r_state;
    logic [STAGE_W-1:0]   r_s;
    logic [BF_W-1:0]      r_b;
    logic [TW_ADDR_W-1:0] r_addr;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_valid;
    logic [STAGE_W-1:0]   r_stage;
    logic [IDX_W-1:0]     r_idx_a;
    logic [IDX_W-1:0]     r_idx_b;
    logic                 r_last;

    logic [STAGE_W-1:0]   w_next_s;
    logic [BF_W-1:0]      w_next_b;
    bf_desc_t             w_next_desc;
    bf_desc_t             w_first_desc;
    logic [W_WIDTH-1:0]   w_rom_real;
    logic [W_WIDTH-1:0]   w_rom_imag;
    logic [W_WIDTH-1:0]   w_w_imag;

    // Next butterfly position: b wraps into the next stage.
    assign w_next_b     = r_b + 2'd1;
    assign w_next_s     = (r_b == 2'd3) ? r_s + 2'd1 : r_s;
    assign w_next_desc  = bf_desc(w_next_s, w_next_b);
    assign w_first_desc = bf_desc(2'd0, 2'd0);

`ifdef TWIDDLE_CONJ_EN
    logic r_inverse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inverse <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_inverse <= inverse;
        end
    end

    // Conjugate by flipping the sign; a zero imaginary part always leaves as +0.0.
    always_comb begin
        w_w_imag = w_rom_imag;
        if (r_inverse) begin
            if (w_rom_imag[W_WIDTH-2:0] == '0) begin
                w_w_imag = '0;
            end else begin
                w_w_imag = {~w_rom_imag[W_WIDTH-1], w_rom_imag[W_WIDTH-2:0]};
            end
        end
    end
`else
    assign w_w_imag = w_rom_imag;
`endif

    twiddle_rom_8pt #(
        .W_WIDTH (W_WIDTH)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr (r_addr),
        .o_real (w_rom_real),
        .o_imag (w_rom_imag)
    );

    // Sequencer FSM; descriptor and ROM address are loaded on entry to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_b     <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_stage <= '0;
            r_idx_a <= '0;
            r_idx_b <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_s     <= '0;
                        r_b     <= '0;
                        r_addr  <= w_first_desc.tw_addr;
                        r_stage <= w_first_desc.stage;
                        r_idx_a <= w_first_desc.idx_a;
                        r_idx_b <= w_first_desc.idx_b;
                        r_last  <= w_first_desc.last;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_valid <= 1'b1;
                    r_state <= VALID;
                end
                VALID: begin
                    if (bf_ready) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_s     <= w_next_s;
                            r_b     <= w_next_b;
                            r_addr  <= w_next_desc.tw_addr;
                            r_stage <= w_next_desc.stage;
                            r_idx_a <= w_next_desc.idx_a;
                            r_idx_b <= w_next_desc.idx_b;
                            r_last  <= w_next_desc.last;
                            r_state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign bf_valid  = r_valid;
    assign bf_stage  = r_stage;
    assign bf_idx_a  = r_idx_a;
    assign bf_idx_b  = r_idx_b;
    assign bf_last   = r_last;
    assign bf_w_real = w_rom_real;
    assign bf_w_imag = w_w_imag;

endmodule

// File: tb/tb_fft8_twiddle_sequencer.sv
// Self-checking bench for fft8_twiddle_sequencer: table of expected descriptors plus
// hand-written stall, mid-frame reset and ignored-start sequences (conj cases with TWIDDLE_CONJ_EN).
module tb_fft8_twiddle_sequencer;

    typedef struct {
        logic [1:0]  stage;
        logic [2:0]  idx_a;
        logic [2:0]  idx_b;
        logic [31:0] w_real;
        logic [31:0] w_imag;
        logic [31:0] w_imag_inv;
        logic        last;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        inverse;
    logic        busy;
    logic        done;
    logic        bf_valid;
    logic        bf_ready;
    logic [1:0]  bf_stage;
    logic [2:0]  bf_idx_a;
    logic [2:0]  bf_idx_b;
    logic [31:0] bf_w_real;
    logic [31:0] bf_w_imag;
    logic        bf_last;

    int   n_tests;
    int   n_fail;
    vec_t vecs[12];

    fft8_twiddle_sequencer #(
        .W_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef TWIDDLE_CONJ_EN
        .inverse   (inverse),
`endif
        .busy      (busy),
        .done      (done),
        .bf_valid  (bf_valid),
        .bf_ready  (bf_ready),
        .bf_stage  (bf_stage),
        .bf_idx_a  (bf_idx_a),
        .bf_idx_b  (bf_idx_b),
        .bf_w_real (bf_w_real),
        .bf_w_imag (bf_w_imag),
        .bf_last   (bf_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [73:0] snap();
        return {bf_valid, bf_last, bf_stage, bf_idx_a, bf_idx_b, bf_w_real, bf_w_imag};
    endfunction

    // One frame from IDLE; mode 0 = ready always high, mode 1 = random stalls (5 on the last).
    task automatic run_frame(input int mode, input bit inv, input bit pulse_start);
        int          idx;
        int          cyc;
        int          dones;
        int          done_cyc;
        int          last_hs;
        int          stall_cnt;
        bit          was_stall;
        bit          rdy;
        logic [73:0] held;
        logic [31:0] exp_im;
        idx = 0; dones = 0; done_cyc = -1; last_hs = -1; stall_cnt = 0; was_stall = 0;
        held = '0;
        start   = 1'b1;
        inverse = inv;
        bf_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk("cycle1_busy_valid", {busy, bf_valid}, 2'b10);
        while (cyc < 300 && (dones == 0 || cyc <= done_cyc + 1)) begin
            if (dones > 0 && cyc > done_cyc)
                chk("after_done_idle", {busy, bf_valid, done}, 3'b000);
            if (bf_valid) begin
                if (was_stall) chk($sformatf("stall_hold%0d", idx), snap(), held);
                if (idx < 12) begin
                    exp_im = inv ? vecs[idx].w_imag_inv : vecs[idx].w_imag;
                    chk($sformatf("desc%0d", idx),
                        {bf_stage, bf_idx_a, bf_idx_b, bf_w_real, bf_w_imag, bf_last},
                        {vecs[idx].stage, vecs[idx].idx_a, vecs[idx].idx_b,
                         vecs[idx].w_real, exp_im, vecs[idx].last});
                end else begin
                    chk("extra_desc", 80'(idx), 80'(11));
                end
                if (mode == 0) rdy = 1'b1;
                else if (idx == 11) rdy = (stall_cnt >= 5);
                else rdy = ($urandom_range(0, 2) != 0);
                bf_ready = rdy;
                if (rdy) begin
                    if (mode == 0) chk($sformatf("hs_cycle%0d", idx), 80'(cyc), 80'(2 + 2 * idx));
                    last_hs   = cyc;
                    idx++;
                    stall_cnt = 0;
                    was_stall = 1'b0;
                end else begin
                    stall_cnt++;
                    was_stall = 1'b1;
                    held      = snap();
                end
            end else begin
                bf_ready  = 1'($urandom_range(0, 1));
                was_stall = 1'b0;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                chk("done_busy_low", {busy, bf_valid}, 2'b00);
                chk("done_after_last_hs", 80'(cyc), 80'(last_hs + 1));
            end
            start = pulse_start && (cyc == 5 || done);
`ifdef TWIDDLE_CONJ_EN
            inverse = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        bf_ready = 1'b0;
        chk("frame_done_count", 80'(dones), 80'(1));
        chk("frame_desc_count", 80'(idx), 80'(12));
        if (mode == 0) chk("done_cycle", 80'(done_cyc), 80'(25));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //                stage idx_a idx_b  w_real        w_imag        w_imag(conj)  last
        vecs[0]  = '{2'd0, 3'd0, 3'd1, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[1]  = '{2'd0, 3'd2, 3'd3, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[2]  = '{2'd0, 3'd4, 3'd5, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[3]  = '{2'd0, 3'd6, 3'd7, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[4]  = '{2'd1, 3'd0, 3'd2, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[5]  = '{2'd1, 3'd1, 3'd3, 32'h00000000, 32'hBF800000, 32'h3F800000, 1'b0};
        vecs[6]  = '{2'd1, 3'd4, 3'd6, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[7]  = '{2'd1, 3'd5, 3'd7, 32'h00000000, 32'hBF800000, 32'h3F800000, 1'b0};
        vecs[8]  = '{2'd2, 3'd0, 3'd4, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[9]  = '{2'd2, 3'd1, 3'd5, 32'h3F3504F3, 32'hBF3504F3, 32'h3F3504F3, 1'b0};
        vecs[10] = '{2'd2, 3'd2, 3'd6, 32'h00000000, 32'hBF800000, 32'h3F800000, 1'b0};
        vecs[11] = '{2'd2, 3'd3, 3'd7, 32'hBF3504F3, 32'hBF3504F3, 32'h3F3504F3, 1'b1};

        rst      = 1'b1;
        start    = 1'b0;
        inverse  = 1'b0;
        bf_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_values", {bf_valid, busy, done, bf_last, bf_stage, bf_idx_a, bf_idx_b},
            {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0});
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_without_start", {bf_valid, busy, done}, 3'b000);

        run_frame(0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run_frame(1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset while stage 1 b=1 is being presented.
        start    = 1'b1;
        bf_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre_rst_desc", {bf_valid, bf_stage, bf_idx_a, bf_idx_b}, {1'b1, 2'd1, 3'd1, 3'd3});
        rst      = 1'b1;
        bf_ready = 1'b0;
        @(negedge clk);
        chk("rst_midframe", {bf_valid, busy, done}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_quiet%0d", i), {bf_valid, busy, done}, 3'b000);
        end
        run_frame(0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        run_frame(0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("no_queued_frame", {bf_valid, busy, done}, 3'b000);

`ifdef TWIDDLE_CONJ_EN
        run_frame(1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        run_frame(0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft8_twiddle_sequencer.md
# fft8_twiddle_sequencer

Schedules the 12 radix-2 DIT butterflies (3 stages × 4) of an 8-point FFT frame and acts as the reader side of the registered twiddle ROM.

- Drives the ROM address and absorbs its one-cycle read latency.
- Presents each butterfly to the downstream butterfly datapath over a valid/ready handshake:
  - operand indices,
  - stage number,
  - IEEE-754 single-precision twiddle.

## Interface

Parameters:
- W_WIDTH, 32, twiddle word width; fixed to IEEE-754 single precision, other values unsupported

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- busy  out  1  high in FETCH and VALID
- done  out  1  one-cycle pulse after the last butterfly handshake
- bf_valid  out  1  butterfly descriptor valid
- bf_ready  in  1  downstream accepts descriptor
- bf_stage  out  2  stage 0..2
- bf_idx_a  out  3  top operand index
- bf_idx_b  out  3  bottom operand index
- bf_w_real  out  32  twiddle real part
- bf_w_imag  out  32  twiddle imaginary part
- bf_last  out  1  high with the final butterfly (stage 2, b=3)
- inverse  in  1  conjugate twiddles; present only with TWIDDLE_CONJ_EN

## Operation

- Counters:
  - stage s (2 bits), 0..2
  - butterfly b (2 bits), 0..3
- Index and twiddle derivation:
  - span = 1<<s
  - j = b mod span
  - idx_a = (b/span)·2·span + j
  - idx_b = idx_a + span
  - twiddle address k = j·(4>>s)
- Resulting k per stage:
  - stage 0: all k = 0
  - stage 1: k = 0,2,0,2
  - stage 2: k = 0,1,2,3
- FSM states:
  - IDLE: start=1 → clear s,b → FETCH.
  - FETCH: ROM address = k of current (s,b); ROM registers it at this edge → VALID.
  - VALID:
    - bf_valid=1; ROM address held, so ROM output stays stable under stall.
    - On bf_valid&bf_ready with last → DONE.
    - Otherwise advance b (on wrap, b→0 and s+1) → FETCH.
  - DONE: done=1 for one cycle → IDLE.
- bf_w_real/bf_w_imag are taken directly from the ROM outputs while in VALID. They are don't-care while bf_valid=0.
- bf_stage, bf_idx_a, bf_idx_b, bf_last are registered and stable throughout VALID.
- start while busy or in DONE is ignored and not queued.
- Reset behaviour:
  - Reset mid-frame returns to IDLE immediately and discards the frame; no done pulse.
  - Reset values: bf_valid=0, busy=0, done=0, bf_last=0, bf_stage=0, bf_idx_a=0, bf_idx_b=0, ROM address=0.
- Counter s never reaches 3; s=3 is unreachable and treated as IDLE-safe (FSM default → IDLE).

## Timing

- start high in cycle 0 (IDLE): FETCH in cycle 1, busy=1 from cycle 1, first bf_valid in cycle 2.
- Throughput: one butterfly per 2 cycles when bf_ready is held high; frame handshakes fall in cycles 2,4,…,24.
- done pulses in cycle 25 with busy=0. Next start is accepted from cycle 26.
- Stall: each cycle with bf_valid=1, bf_ready=0 adds one cycle; all bf_* outputs are held bit-stable.
- bf_ready is ignored when bf_valid=0.

## Configuration

- TWIDDLE_CONJ_EN defined:
  - Port inverse exists and is latched at start; changes mid-frame have no effect.
  - When latched inverse=1, bit 31 of bf_w_imag is inverted. Exception: bits 30:0 all zero, where +0.0 is output.
  - bf_w_real is unchanged.
- TWIDDLE_CONJ_EN undefined: no inverse port; forward twiddles only.

## Structure

- Shared package fft8_pkg holds:
  - FFT_N=8, FFT_LOG2N=3, FFT_BF_PER_STAGE=4
  - FSM state enum (IDLE, FETCH, VALID, DONE)
  - twiddle address width (2)
- Sub-module: twiddle_rom_8pt is instantiated internally, driven by the sequencer's registered address.
- All other logic (counters, FSM, index math) is in this module.

## Test plan

- Full frame, bf_ready=1 → 12 handshakes in cycles 2..24, done in cycle 25, bf_last only on the 12th.
- Index/twiddle checks:
  - stage 0 b=2 → idx 4/5, w=3F800000/00000000
  - stage 1 b=3 → idx 5/7, w=00000000/BF800000
  - stage 2 b=1 → idx 1/5, w=3F3504F3/BF3504F3
- Random bf_ready stalls (including 5-cycle stall on stage 2 b=3) → outputs bit-stable during stall, same 12-descriptor sequence, single done.
- rst asserted during stage 1 b=1 → next cycle bf_valid=0, busy=0, no done; a following start replays from stage 0 b=0.
- start pulsed during busy and in the DONE cycle → ignored; exactly one frame produced.
- With TWIDDLE_CONJ_EN, inverse=1:
  - stage 2 b=3 → w_imag=3F3504F3
  - stage 0 → w_imag=00000000 (not 80000000)
